// File: rtl/array_access_if.sv
// rtl/array_access_if.sv - request/decoder bundle between host sequencer and array access controller
// Purpose: groups the request strobe/address inputs and the decoder drive/status
//          outputs of array_access_ctrl.
// Ports (signals):
//   start, mode, row_addr, col_addr   request from host (master -> slave)
//   abort                             request termination, only with ARRAY_CTRL_ABORT_EN
//   en, row_sel, col_sel              decoder enable and selects (slave -> master)
//   cell_valid, busy, done, err       per-cell and request status (slave -> master)
// Modports: master = host side, slave = controller side.
interface array_access_if #(
    parameter int COL_NO      = 8,
    parameter int PAIR_ROW_NO = 4
);
    localparam int RW = $clog2(PAIR_ROW_NO);
    localparam int CW = $clog2(COL_NO);

    logic          start;
    logic          mode;
    logic [RW-1:0] row_addr;
    logic [CW-1:0] col_addr;
`ifdef ARRAY_CTRL_ABORT_EN
    logic          abort;
`endif
    logic          en;
    logic [RW-1:0] row_sel;
    logic [CW-1:0] col_sel;
    logic          cell_valid;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
`ifdef ARRAY_CTRL_ABORT_EN
        output abort,
`endif
        output start, mode, row_addr, col_addr,
        input  en, row_sel, col_sel, cell_valid, busy, done, err
    );

    modport slave (
`ifdef ARRAY_CTRL_ABORT_EN
        input  abort,
`endif
        input  start, mode, row_addr, col_addr,
        output en, row_sel, col_sel, cell_valid, busy, done, err
    );
endinterface

// File: rtl/array_access_ctrl.sv
// rtl/array_access_ctrl.sv - setup/pulse/hold sequencer for crossbar row/column decoders
// Purpose: accepts single-cell or full-array scan requests and drives decoder enable
//          and pair-row/column selects so selects are stable around every en pulse.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   array_access_if.slave: start/mode/row_addr/col_addr in,
//         en/row_sel/col_sel/cell_valid/busy/done/err out (all registered)
// Optional feature: define ARRAY_CTRL_ABORT_EN to add the abort input.
module array_access_ctrl #(
    parameter int COL_NO      = 8,
    parameter int PAIR_ROW_NO = 4,
    parameter int SETUP_CYC   = 1,
    parameter int PULSE_CYC   = 4,
    parameter int HOLD_CYC    = 1
) (
    input  logic clk,
    input  logic rst,
    array_access_if.slave bus
);
    localparam int RW     = $clog2(PAIR_ROW_NO);
    localparam int CW     = $clog2(COL_NO);
    localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_C  = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CNT_W  = $clog2(MAX_C + 1);

    // Phase counter holds "cycles left in this state minus one".
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [RW-1:0]    ROW_LAST = RW'(PAIR_ROW_NO - 1);
    localparam logic [CW-1:0]    COL_LAST = CW'(COL_NO - 1);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    state_t         state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [RW-1:0]  row_q, row_n;
    logic [CW-1:0]  col_q, col_n;
    logic           mode_q, mode_n;
    logic           en_q, cv_q, busy_q, done_q, err_q;
    logic           done_n, err_n;
    logic           addr_bad, last_cell, finish, fin_err;
`ifdef ARRAY_CTRL_ABORT_EN
    logic           abort_q, abort_n;
`endif

    assign addr_bad  = (int'(bus.row_addr) >= PAIR_ROW_NO) || (int'(bus.col_addr) >= COL_NO);
    assign last_cell = (row_q == ROW_LAST) && (col_q == COL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            row_q  <= '0;
            col_q  <= '0;
            mode_q <= 1'b0;
            en_q   <= 1'b0;
            cv_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
`ifdef ARRAY_CTRL_ABORT_EN
            abort_q <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            row_q  <= row_n;
            col_q  <= col_n;
            mode_q <= mode_n;
            // Outputs are registered copies of what the next state implies.
            en_q   <= (state_n == PULSE);
            cv_q   <= (state_n == HOLD) && (cnt_n == '0);
            busy_q <= (state_n != IDLE);
            done_q <= done_n;
            err_q  <= err_n;
`ifdef ARRAY_CTRL_ABORT_EN
            abort_q <= abort_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        row_n   = row_q;
        col_n   = col_q;
        mode_n  = mode_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        finish  = !mode_q || last_cell;
        fin_err = 1'b0;
`ifdef ARRAY_CTRL_ABORT_EN
        abort_n = abort_q;
        // An abort seen during PULSE or HOLD lets the current cell finish.
        if ((state == PULSE || state == HOLD) && bus.abort) abort_n = 1'b1;
        fin_err = abort_q || bus.abort;
        finish  = finish || fin_err;
`endif
        case (state)
            IDLE: begin
`ifdef ARRAY_CTRL_ABORT_EN
                abort_n = 1'b0;
`endif
                if (bus.start) begin
                    mode_n = bus.mode;
                    if (!bus.mode && addr_bad) begin
                        done_n = 1'b1;
                        err_n  = 1'b1;
                    end else begin
                        state_n = SETUP;
                        cnt_n   = SETUP_LD;
                        row_n   = bus.mode ? '0 : bus.row_addr;
                        col_n   = bus.mode ? '0 : bus.col_addr;
                    end
                end
            end
            SETUP: begin
`ifdef ARRAY_CTRL_ABORT_EN
                if (bus.abort) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    err_n   = 1'b1;
                end else
`endif
                if (cnt == '0) begin
                    state_n = PULSE;
                    cnt_n   = PULSE_LD;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_n = HOLD;
                    cnt_n   = HOLD_LD;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else if (finish) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    err_n   = fin_err;
                end else begin
                    // Selects only move here, while en is guaranteed low.
                    state_n = SETUP;
                    cnt_n   = SETUP_LD;
                    if (col_q == COL_LAST) begin
                        col_n = '0;
                        row_n = row_q + RW'(1);
                    end else begin
                        col_n = col_q + CW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.en         = en_q;
    assign bus.row_sel    = row_q;
    assign bus.col_sel    = col_q;
    assign bus.cell_valid = cv_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule
